// File: rtl/serial_pkg.sv
//------------------------------------------------------------------------------
// Module  : serial_pkg
// Brief   : Shared receiver state encoding and default frame parameters.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_pkg;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_PARITY_EN  = 1;
    localparam int unsigned DEF_PARITY_ODD = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

endpackage : serial_pkg

`default_nettype wire

// File: rtl/rx_shift_reg.sv
//------------------------------------------------------------------------------
// Module  : rx_shift_reg
// Brief   : DATA_W-bit right-shift register; serial bits enter at the MSB.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rx_shift_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en_i,
    input  logic              sin_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    // After DATA_W shifts the first bit received has moved down to bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (shift_en_i) begin
            data_q <= {sin_i, data_q[DATA_W-1:1]};
        end
    end

    assign data_o = data_q;

endmodule : rx_shift_reg

`default_nettype wire

// File: rtl/serial_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : serial_frame_rx
// Brief   : Strobed serial frame receiver (start, LSB-first data, parity, stop).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned PARITY_EN  = DEF_PARITY_EN,
    parameter int unsigned PARITY_ODD = DEF_PARITY_ODD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W    = $clog2(DATA_W + 1);
    localparam logic        ODD_BIT  = (PARITY_ODD != 0);
    localparam logic        HAS_PAR  = (PARITY_EN != 0);

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               perr_flag_q, perr_flag_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;

    logic               w_shift_en;
    logic [DATA_W-1:0]  w_shift_data;

    assign w_shift_en = bit_en && (state_q == ST_DATA);

    rx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (w_shift_en),
        .sin_i      (sin),
        .data_o     (w_shift_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            perr_flag_q  <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            perr_flag_q  <= perr_flag_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Status pulses default low every cycle, so they last exactly one clk.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        perr_flag_d  = perr_flag_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bit_en && !sin) begin
                    state_d     = ST_DATA;
                    cnt_d       = '0;
                    perr_flag_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_en) begin
                    perr_flag_d = ((^w_shift_data) ^ ODD_BIT) != sin;
                    state_d     = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_en) begin
                    state_d = ST_IDLE;
                    if (sin) begin
                        dout_d       = w_shift_data;
                        dout_valid_d = 1'b1;
                        parity_err_d = perr_flag_q;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule : serial_frame_rx

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_serial_frame_rx
// Brief   : Directed self-checking bench for serial_frame_rx (8 data, even).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_frame_rx;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       sin;
    logic [7:0] dout;
    logic       dout_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_frame_rx #(
        .DATA_W     (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Presents one bit for a single strobed edge, then idles the strobe for gap-1 cycles.
    task automatic sample_bit(input logic b, input int gap, input bit chk_busy);
        sin    = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        for (int i = 1; i < gap; i++) begin
            if (chk_busy) check_eq("busy_in_frame", {15'd0, busy}, 16'd1);
            @(negedge clk);
        end
    endtask

    // Leaves the caller at the negedge just after the stop-bit sampling edge.
    task automatic send_frame(input logic [7:0] data, input logic par_flip,
                              input logic stop_b, input int gap, input bit chk_busy);
        sample_bit(1'b0, gap, chk_busy);
        for (int i = 0; i < 8; i++) sample_bit(data[i], gap, chk_busy);
        sample_bit((^data) ^ par_flip, gap, chk_busy);
        sample_bit(stop_b, 1, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic v,
                              input logic pe, input logic fe, input logic bz);
        check_eq({tag, "_dout"}, {8'd0, dout}, {8'd0, d});
        check_eq({tag, "_valid"}, {15'd0, dout_valid}, {15'd0, v});
        check_eq({tag, "_perr"}, {15'd0, parity_err}, {15'd0, pe});
        check_eq({tag, "_ferr"}, {15'd0, frame_err}, {15'd0, fe});
        check_eq({tag, "_busy"}, {15'd0, busy}, {15'd0, bz});
    endtask

    initial begin
        sin    = 1'b1;
        bit_en = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Idle line with strobes must not start a frame.
        bit_en = 1'b1;
        repeat (2) @(negedge clk);
        bit_en = 1'b0;
        check_outs("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0);
        check_outs("good_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("good_a5_after", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0);
        check_outs("perr_a5", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("perr_a5_after", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);
        check_outs("ferr_3c", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_outs("ferr_3c_after", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'h81, 1'b0, 1'b1, 4, 1'b1);
        check_outs("gap_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("gap_81_after", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort a frame after three data bits with an asynchronous reset.
        sample_bit(1'b0, 1, 1'b0);
        sample_bit(1'b1, 1, 1'b0);
        sample_bit(1'b0, 1, 1'b0);
        sample_bit(1'b1, 1, 1'b0);
        check_eq("mid_busy", {15'd0, busy}, 16'd1);
        #2 rst = 1'b1;
        #1 check_outs("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0);
        check_outs("after_rst_5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back: the next start bit follows the stop bit directly.
        send_frame(8'h01, 1'b0, 1'b1, 1, 1'b0);
        check_outs("b2b_01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFE, 1'b0, 1'b1, 1, 1'b0);
        check_outs("b2b_fe", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("b2b_fe_after", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_frame_rx

`default_nettype wire
